// File: rtl/vcve2_pkg.sv
// Shared vcve2 types and constants: SEW encodings, sequencer states, default VLEN.
package vcve2_pkg;

    localparam int unsigned VLEN_DEFAULT = 128;

    localparam logic [2:0] VSEW_8  = 3'd0;
    localparam logic [2:0] VSEW_16 = 3'd1;
    localparam logic [2:0] VSEW_32 = 3'd2;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } vseq_state_e;

    function automatic logic vsew_legal(input logic [2:0] vsew);
        return (vsew == VSEW_8) || (vsew == VSEW_16) || (vsew == VSEW_32);
    endfunction

endpackage

// File: rtl/vcve2_vseq_be_gen.sv
// Write byte-enable generator for the vector sequencer: tail trimming on the last word,
// plus mask-undisturbed clearing of inactive elements when VCVE2_VSEQ_MASK_EN is defined.
module vcve2_vseq_be_gen
    import vcve2_pkg::*;
#(
    parameter  int unsigned VLEN = VLEN_DEFAULT,
    localparam int unsigned NW   = VLEN / 32,
    localparam int unsigned WIW  = $clog2(NW)
) (
    input  logic [WIW-1:0]  idx,
    input  logic [WIW:0]    words,
    input  logic [1:0]      rem,
    input  logic [1:0]      vsew,
`ifdef VCVE2_VSEQ_MASK_EN
    input  logic            vm,
    input  logic [VLEN-1:0] v0,
`endif
    output logic [3:0]      wbe
);

    localparam logic [WIW:0] ONE_WORD = (WIW + 1)'(1);

    logic       last_word;
    logic [3:0] tail_be;

    assign last_word = (({1'b0, idx} + ONE_WORD) == words);

    always_comb begin
        tail_be = 4'hF;
        if (last_word) begin
            case (rem)
                2'd1:    tail_be = 4'b0001;
                2'd2:    tail_be = 4'b0011;
                2'd3:    tail_be = 4'b0111;
                default: tail_be = 4'hF;
            endcase
        end
    end

`ifdef VCVE2_VSEQ_MASK_EN
    localparam int unsigned VIW = $clog2(VLEN);

    logic [3:0]     mask_be;
    logic [VIW-1:0] elem;

    // byte b of word idx belongs to element ({idx,b} >> vsew); its v0 bit gates it
    always_comb begin
        mask_be = 4'hF;
        elem    = '0;
        if (!vm) begin
            for (int b = 0; b < 4; b++) begin
                elem = VIW'({idx, 2'(b)}) >> vsew;
                if (!v0[elem]) begin
                    mask_be[b] = 1'b0;
                end
            end
        end
    end

    assign wbe = tail_be & mask_be;
`else
    assign wbe = tail_be;
`endif

endmodule

// File: rtl/vcve2_vec_sequencer.sv
// Vector element sequencer: walks source registers one 32-bit word at a time through EX
// and writes results back to the VRF. Element masking is enabled by VCVE2_VSEQ_MASK_EN.
//
// state | meaning
// IDLE  | waiting for start_i from ID
// EXEC  | feeding word idx to EX, writing back on ex_valid_i
// DONE  | one-cycle completion, done_o high
module vcve2_vec_sequencer
    import vcve2_pkg::*;
#(
    parameter  int unsigned VLEN = VLEN_DEFAULT,
    localparam int unsigned NW   = VLEN / 32,
    localparam int unsigned WIW  = $clog2(NW),
    localparam int unsigned VLW  = $clog2(VLEN / 8) + 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            kill_i,
    input  logic [VLW-1:0]  vl_i,
    input  logic [2:0]      vsew_i,
    input  logic [4:0]      vs1_i,
    input  logic [4:0]      vs2_i,
    input  logic [4:0]      vd_i,
    input  logic            vx_sel_i,
    input  logic [31:0]     scalar_i,
`ifdef VCVE2_VSEQ_MASK_EN
    input  logic            vm_i,
    input  logic [VLEN-1:0] v0_i,
`endif
    output logic [4:0]      vrf_raddr_a_o,
    output logic [4:0]      vrf_raddr_b_o,
    output logic [WIW-1:0]  vrf_rword_o,
    input  logic [31:0]     vrf_rdata_a_i,
    input  logic [31:0]     vrf_rdata_b_i,
    output logic [31:0]     ex_operand_a_o,
    output logic [31:0]     ex_operand_b_o,
    output logic            ex_instr_first_cycle_o,
    output logic            ex_vec_instr_o,
    output logic [2:0]      ex_vsew_o,
    input  logic            ex_valid_i,
    input  logic [31:0]     ex_result_i,
    output logic            vrf_we_o,
    output logic [4:0]      vrf_waddr_o,
    output logic [WIW-1:0]  vrf_wword_o,
    output logic [31:0]     vrf_wdata_o,
    output logic [3:0]      vrf_wbe_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            illegal_o
);

    localparam logic [VLW-1:0] BYTES_PER_REG = VLW'(VLEN / 8);
    localparam logic [WIW:0]   ONE_WORD      = (WIW + 1)'(1);
    localparam logic [WIW-1:0] ONE_IDX       = WIW'(1);

    vseq_state_e    state_q;
    logic [WIW-1:0] idx_q;
    logic [WIW:0]   words_q;
    logic [1:0]     rem_q;
    logic [4:0]     vd_q;
    logic           vx_sel_q;
    logic [31:0]    scalar_q;
    logic           first_q;
`ifdef VCVE2_VSEQ_MASK_EN
    logic           vm_q;
`endif

    logic [VLW-1:0] vlmax_c;
    logic [VLW-1:0] vl_c;
    logic [VLW-1:0] bytes_c;
    logic [WIW:0]   words_c;
    logic           exec_c;
    logic           step_c;
    logic           last_c;
    logic [3:0]     wbe_c;

    // instruction geometry from the raw ID fields; only meaningful for legal vsew
    always_comb begin
        vlmax_c = BYTES_PER_REG >> vsew_i[1:0];
        vl_c    = (vl_i > vlmax_c) ? vlmax_c : vl_i;
        bytes_c = vl_c << vsew_i[1:0];
        words_c = (WIW + 1)'((bytes_c + VLW'(3)) >> 2);
    end

    assign exec_c = (state_q == EXEC);
    assign step_c = exec_c && ex_valid_i && !kill_i;
    assign last_c = (({1'b0, idx_q} + ONE_WORD) == words_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            words_q        <= '0;
            rem_q          <= '0;
            vd_q           <= '0;
            vx_sel_q       <= 1'b0;
            scalar_q       <= '0;
            first_q        <= 1'b0;
`ifdef VCVE2_VSEQ_MASK_EN
            vm_q           <= 1'b1;
`endif
            vrf_raddr_a_o  <= '0;
            vrf_raddr_b_o  <= '0;
            ex_vsew_o      <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            illegal_o      <= 1'b0;
            ex_vec_instr_o <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            illegal_o <= 1'b0;
            if (kill_i) begin
                state_q        <= IDLE;
                busy_o         <= 1'b0;
                ex_vec_instr_o <= 1'b0;
                first_q        <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            if (!vsew_legal(vsew_i)) begin
                                illegal_o <= 1'b1;
                            end else begin
                                vrf_raddr_a_o <= vs2_i;
                                vrf_raddr_b_o <= vs1_i;
                                vd_q          <= vd_i;
                                vx_sel_q      <= vx_sel_i;
                                scalar_q      <= scalar_i;
                                ex_vsew_o     <= vsew_i;
                                words_q       <= words_c;
                                rem_q         <= bytes_c[1:0];
`ifdef VCVE2_VSEQ_MASK_EN
                                vm_q          <= vm_i;
`endif
                                idx_q         <= '0;
                                first_q       <= 1'b1;
                                busy_o        <= 1'b1;
                                if (words_c == '0) begin
                                    state_q <= DONE;
                                    done_o  <= 1'b1;
                                end else begin
                                    state_q        <= EXEC;
                                    ex_vec_instr_o <= 1'b1;
                                end
                            end
                        end
                    end
                    EXEC: begin
                        if (ex_valid_i) begin
                            first_q <= 1'b1;
                            if (last_c) begin
                                state_q        <= DONE;
                                done_o         <= 1'b1;
                                ex_vec_instr_o <= 1'b0;
                            end else begin
                                idx_q <= idx_q + ONE_IDX;
                            end
                        end else begin
                            first_q <= 1'b0;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_o  <= 1'b0;
                    end
                endcase
            end
        end
    end

    vcve2_vseq_be_gen #(
        .VLEN (VLEN)
    ) u_be_gen (
        .idx   (idx_q),
        .words (words_q),
        .rem   (rem_q),
        .vsew  (ex_vsew_o[1:0]),
`ifdef VCVE2_VSEQ_MASK_EN
        .vm    (vm_q),
        .v0    (v0_i),
`endif
        .wbe   (wbe_c)
    );

    // a fully masked word still consumes its EX slot but writes nothing
    assign vrf_we_o               = step_c && (wbe_c != 4'h0);
    assign vrf_rword_o            = idx_q;
    assign vrf_wword_o            = idx_q;
    assign vrf_waddr_o            = vd_q;
    assign vrf_wdata_o            = vrf_we_o ? ex_result_i : '0;
    assign vrf_wbe_o              = vrf_we_o ? wbe_c : 4'h0;
    assign ex_operand_a_o         = exec_c ? vrf_rdata_a_i : '0;
    assign ex_operand_b_o         = !exec_c ? '0 : (vx_sel_q ? scalar_q : vrf_rdata_b_i);
    assign ex_instr_first_cycle_o = exec_c && first_q;

endmodule

// File: tb/tb_vcve2_vec_sequencer.sv
// Directed bench for vcve2_vec_sequencer with a pattern VRF and an adder standing in for EX.
`timescale 1ns/1ps
module tb_vcve2_vec_sequencer;
    import vcve2_pkg::*;

    localparam int unsigned VLEN = 128;
    localparam int unsigned WIW  = 2;
    localparam int unsigned VLW  = 5;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            start_i;
    logic            kill_i;
    logic [VLW-1:0]  vl_i;
    logic [2:0]      vsew_i;
    logic [4:0]      vs1_i;
    logic [4:0]      vs2_i;
    logic [4:0]      vd_i;
    logic            vx_sel_i;
    logic [31:0]     scalar_i;
    logic [4:0]      vrf_raddr_a_o;
    logic [4:0]      vrf_raddr_b_o;
    logic [WIW-1:0]  vrf_rword_o;
    logic [31:0]     vrf_rdata_a_i;
    logic [31:0]     vrf_rdata_b_i;
    logic [31:0]     ex_operand_a_o;
    logic [31:0]     ex_operand_b_o;
    logic            ex_instr_first_cycle_o;
    logic            ex_vec_instr_o;
    logic [2:0]      ex_vsew_o;
    logic            ex_valid_i;
    logic [31:0]     ex_result_i;
    logic            vrf_we_o;
    logic [4:0]      vrf_waddr_o;
    logic [WIW-1:0]  vrf_wword_o;
    logic [31:0]     vrf_wdata_o;
    logic [3:0]      vrf_wbe_o;
    logic            busy_o;
    logic            done_o;
    logic            illegal_o;

    always #5 clk_i = ~clk_i;

    vcve2_vec_sequencer #(.VLEN(VLEN)) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .start_i                (start_i),
        .kill_i                 (kill_i),
        .vl_i                   (vl_i),
        .vsew_i                 (vsew_i),
        .vs1_i                  (vs1_i),
        .vs2_i                  (vs2_i),
        .vd_i                   (vd_i),
        .vx_sel_i               (vx_sel_i),
        .scalar_i               (scalar_i),
`ifdef VCVE2_VSEQ_MASK_EN
        .vm_i                   (1'b1),
        .v0_i                   ({VLEN{1'b0}}),
`endif
        .vrf_raddr_a_o          (vrf_raddr_a_o),
        .vrf_raddr_b_o          (vrf_raddr_b_o),
        .vrf_rword_o            (vrf_rword_o),
        .vrf_rdata_a_i          (vrf_rdata_a_i),
        .vrf_rdata_b_i          (vrf_rdata_b_i),
        .ex_operand_a_o         (ex_operand_a_o),
        .ex_operand_b_o         (ex_operand_b_o),
        .ex_instr_first_cycle_o (ex_instr_first_cycle_o),
        .ex_vec_instr_o         (ex_vec_instr_o),
        .ex_vsew_o              (ex_vsew_o),
        .ex_valid_i             (ex_valid_i),
        .ex_result_i            (ex_result_i),
        .vrf_we_o               (vrf_we_o),
        .vrf_waddr_o            (vrf_waddr_o),
        .vrf_wword_o            (vrf_wword_o),
        .vrf_wdata_o            (vrf_wdata_o),
        .vrf_wbe_o              (vrf_wbe_o),
        .busy_o                 (busy_o),
        .done_o                 (done_o),
        .illegal_o              (illegal_o)
    );

    // VRF contents are a fixed pattern of (register, word)
    function automatic logic [31:0] vrf_val(input int r, input int w);
        logic [4:0] rr;
        logic [1:0] ww;
        rr = r[4:0];
        ww = w[1:0];
        return {3'b000, rr, 6'b000000, ww, 16'hC0DE};
    endfunction

    assign vrf_rdata_a_i = vrf_val(int'(vrf_raddr_a_o), int'(vrf_rword_o));
    assign vrf_rdata_b_i = vrf_val(int'(vrf_raddr_b_o), int'(vrf_rword_o));
    assign ex_result_i   = ex_operand_a_o + ex_operand_b_o;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    endtask

    // cycle counter and write/done monitor, sampled mid-cycle on the falling edge
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int          start_cyc = 0;
    int          nwr = 0, ndone = 0, nbusy = 0, nfirst = 0, nillegal = 0, done_at = 0;
    logic [3:0]  wr_be   [256];
    logic [31:0] wr_data [256];
    logic [1:0]  wr_word [256];
    logic [4:0]  wr_addr [256];
    int          wr_cyc  [256];

    always @(negedge clk_i) begin
        if (vrf_we_o) begin
            if (nwr < 256) begin
                wr_be[nwr]   = vrf_wbe_o;
                wr_data[nwr] = vrf_wdata_o;
                wr_word[nwr] = vrf_wword_o;
                wr_addr[nwr] = vrf_waddr_o;
                wr_cyc[nwr]  = cyc - start_cyc;
            end
            nwr++;
        end
        if (done_o) begin
            ndone++;
            done_at = cyc - start_cyc;
        end
        if (busy_o) nbusy++;
        if (ex_instr_first_cycle_o) nfirst++;
        if (illegal_o) nillegal++;
    end

    int wr_base = 0, done_base = 0, busy_base = 0, first_base = 0, ill_base = 0;

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic start_instr(input logic [4:0] vl, input logic [2:0] vsew, input logic [4:0] vs1,
                               input logic [4:0] vs2, input logic [4:0] vd, input logic vx,
                               input logic [31:0] sc);
        wr_base    = nwr;
        done_base  = ndone;
        busy_base  = nbusy;
        first_base = nfirst;
        ill_base   = nillegal;
        vl_i       = vl;
        vsew_i     = vsew;
        vs1_i      = vs1;
        vs2_i      = vs2;
        vd_i       = vd;
        vx_sel_i   = vx;
        scalar_i   = sc;
        start_i    = 1'b1;
        start_cyc  = cyc;
        step();
        start_i    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (ndone == done_base && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_done_cnt"}, 32'(ndone - done_base), 32'd1);
    endtask

    typedef struct packed {
        logic [4:0] vl;
        logic [2:0] vsew;
        logic [3:0] nw;
        logic [3:0] last_be;
    } vec_t;

    // vl, vsew, expected writes, expected byte enables on the last word
    vec_t tbl [10] = '{
        '{5'd6,  3'd0, 4'd2, 4'b0011},
        '{5'd0,  3'd2, 4'd0, 4'b0000},
        '{5'd24, 3'd1, 4'd4, 4'b1111},
        '{5'd1,  3'd0, 4'd1, 4'b0001},
        '{5'd3,  3'd0, 4'd1, 4'b0111},
        '{5'd3,  3'd1, 4'd2, 4'b0011},
        '{5'd31, 3'd0, 4'd4, 4'b1111},
        '{5'd5,  3'd2, 4'd4, 4'b1111},
        '{5'd7,  3'd0, 4'd2, 4'b0111},
        '{5'd5,  3'd1, 4'd3, 4'b0011}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; kill_i = 1'b0; vl_i = '0; vsew_i = '0;
        vs1_i = '0; vs2_i = '0; vd_i = '0; vx_sel_i = 1'b0; scalar_i = '0; ex_valid_i = 1'b1;
        #12;
        chk("rst_busy",   32'(busy_o), 32'd0);
        chk("rst_done",   32'(done_o), 32'd0);
        chk("rst_ill",    32'(illegal_o), 32'd0);
        chk("rst_we",     32'(vrf_we_o), 32'd0);
        chk("rst_vec",    32'(ex_vec_instr_o), 32'd0);
        chk("rst_first",  32'(ex_instr_first_cycle_o), 32'd0);
        chk("rst_opa",    ex_operand_a_o, 32'd0);
        chk("rst_wbe",    32'(vrf_wbe_o), 32'd0);
        rst_ni = 1'b1;
        step();

        // vv add, SEW32, four full words
        start_instr(5'd4, 3'd2, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0);
        chk("t1_busy",  32'(busy_o), 32'd1);
        chk("t1_vec",   32'(ex_vec_instr_o), 32'd1);
        chk("t1_vsew",  32'(ex_vsew_o), 32'd2);
        chk("t1_ra",    32'(vrf_raddr_a_o), 32'd2);
        chk("t1_rb",    32'(vrf_raddr_b_o), 32'd1);
        wait_done("t1");
        chk("t1_nwr",   32'(nwr - wr_base), 32'd4);
        chk("t1_dcyc",  32'(done_at), 32'd5);
        chk("t1_idle",  32'(busy_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_w%0d_word", k), 32'(wr_word[wr_base + k]), 32'(k));
            chk($sformatf("t1_w%0d_cyc", k),  32'(wr_cyc[wr_base + k]), 32'(k + 1));
            chk($sformatf("t1_w%0d_data", k), wr_data[wr_base + k], vrf_val(2, k) + vrf_val(1, k));
            chk($sformatf("t1_w%0d_be", k),   32'(wr_be[wr_base + k]), 32'hF);
            chk($sformatf("t1_w%0d_addr", k), 32'(wr_addr[wr_base + k]), 32'd3);
        end

        for (int i = 0; i < 10; i++) begin
            start_instr(tbl[i].vl, tbl[i].vsew, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0);
            wait_done($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d_nwr", i),   32'(nwr - wr_base), 32'(tbl[i].nw));
            chk($sformatf("tbl%0d_dcyc", i),  32'(done_at), 32'(tbl[i].nw) + 32'd1);
            chk($sformatf("tbl%0d_busy", i),  32'(nbusy - busy_base), 32'(tbl[i].nw) + 32'd1);
            chk($sformatf("tbl%0d_first", i), 32'(nfirst - first_base), 32'(tbl[i].nw));
            if (tbl[i].nw != 4'd0)
                chk($sformatf("tbl%0d_lastbe", i), 32'(wr_be[wr_base + int'(tbl[i].nw) - 1]),
                    32'(tbl[i].last_be));
        end

        // .vx form, in-place destination
        start_instr(5'd2, 3'd2, 5'd1, 5'd4, 5'd4, 1'b1, 32'h0000_0100);
        wait_done("vx");
        chk("vx_nwr", 32'(nwr - wr_base), 32'd2);
        for (int k = 0; k < 2; k++)
            chk($sformatf("vx_w%0d_data", k), wr_data[wr_base + k], vrf_val(4, k) + 32'h0000_0100);

        // multi-cycle EX: three stall cycles per word, a stray start_i mid-flight
        ex_valid_i = 1'b0;
        start_instr(5'd2, 3'd2, 5'd5, 5'd6, 5'd7, 1'b0, 32'd0);
        for (int w = 0; w < 2; w++) begin
            for (int j = 0; j < 3; j++) begin
                start_i = (w == 0 && j == 1);
                if (start_i) vd_i = 5'd9;
                #1;
                chk($sformatf("md_w%0d_c%0d_first", w, j), 32'(ex_instr_first_cycle_o), (j == 0) ? 32'd1 : 32'd0);
                chk($sformatf("md_w%0d_c%0d_opa", w, j), ex_operand_a_o, vrf_val(6, w));
                chk($sformatf("md_w%0d_c%0d_opb", w, j), ex_operand_b_o, vrf_val(5, w));
                chk($sformatf("md_w%0d_c%0d_we", w, j), 32'(vrf_we_o), 32'd0);
                step();
                start_i = 1'b0;
            end
            ex_valid_i = 1'b1;
            #1;
            chk($sformatf("md_w%0d_we", w),   32'(vrf_we_o), 32'd1);
            chk($sformatf("md_w%0d_word", w), 32'(vrf_wword_o), 32'(w));
            chk($sformatf("md_w%0d_data", w), vrf_wdata_o, vrf_val(6, w) + vrf_val(5, w));
            step();
            ex_valid_i = 1'b0;
        end
        ex_valid_i = 1'b1;
        wait_done("md");
        chk("md_nwr",   32'(nwr - wr_base), 32'd2);
        chk("md_first", 32'(nfirst - first_base), 32'd2);
        chk("md_waddr", 32'(wr_addr[wr_base + 1]), 32'd7);

        // illegal SEW
        start_instr(5'd4, 3'd3, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0);
        chk("ill_pulse", 32'(illegal_o), 32'd1);
        chk("ill_busy",  32'(busy_o), 32'd0);
        step(); step(); step();
        chk("ill_cnt",  32'(nillegal - ill_base), 32'd1);
        chk("ill_nwr",  32'(nwr - wr_base), 32'd0);
        chk("ill_done", 32'(ndone - done_base), 32'd0);

        // kill together with ex_valid_i on word 1
        start_instr(5'd4, 3'd2, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0);
        step();
        kill_i = 1'b1;
        #1;
        chk("kill_we", 32'(vrf_we_o), 32'd0);
        step();
        kill_i = 1'b0;
        chk("kill_busy", 32'(busy_o), 32'd0);
        chk("kill_vec",  32'(ex_vec_instr_o), 32'd0);
        step(); step();
        chk("kill_nwr",  32'(nwr - wr_base), 32'd1);
        chk("kill_done", 32'(ndone - done_base), 32'd0);

        start_instr(5'd4, 3'd2, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0);
        wait_done("post_kill");
        chk("post_kill_nwr",  32'(nwr - wr_base), 32'd4);
        chk("post_kill_last", 32'(wr_word[wr_base + 3]), 32'd3);

        // asynchronous reset in the middle of an instruction
        start_instr(5'd4, 3'd2, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0);
        step();
        rst_ni = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_we",   32'(vrf_we_o), 32'd0);
        chk("arst_opa",  ex_operand_a_o, 32'd0);
        #1;
        rst_ni = 1'b1;
        step(); step();
        chk("arst_nwr",  32'(nwr - wr_base), 32'd1);
        chk("arst_done", 32'(ndone - done_base), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
